projectile_pool: RTL and testbench

Multi-slot projectile engine. It replaces the single-projectile FSM, move and draw chain with a pool of NUM_SLOTS independent projectiles shared by player and enemy shooters. The block handles slot allocation, per-frame fixed-point motion, collision retirement and a prioritised pixel hit-test. It sits between the shooter logic and the video mux, and its bitmap offsets feed the shared projectile bitmap ROM.

---
 rtl/projectile_pkg.sv | 10 +
 rtl/projectile_slot.sv | 109 ++++++++++
 rtl/projectile_pool.sv | 152 +++++++++++++++
 tb/tb_projectile_pool.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/projectile_pkg.sv
// Shared types for the projectile pool: slot lifecycle, shooter ownership and
// the signed fixed-point position format.
package projectile_pkg;
  localparam int FRAC_BITS = 6;
  localparam int POS_W     = 12 + FRAC_BITS;

  typedef enum logic [1:0] {IDLE = 2'd0, FLYING = 2'd1, HIT = 2'd2} slot_state_t;
  typedef enum logic {PLAYER = 1'b0, ENEMY = 1'b1} owner_t;
  typedef logic signed [POS_W-1:0] pos_t;
endpackage

// File: rtl/projectile_slot.sv
// One projectile slot: lifecycle state, launch latch, fixed-point Y motion and
// the rectangle test of the current pixel against the slot.
module projectile_slot
  import projectile_pkg::*;
#(
  parameter int OBJ_W    = 32,
  parameter int OBJ_H    = 32,
  parameter int SCREEN_H = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alloc_i,
  input  logic        enemy_i,
  input  logic [10:0] x_i,
  input  logic [10:0] y_i,
  input  logic [15:0] speed_i,
  input  logic        frame_i,
  input  logic        collide_i,
  input  logic        flush_i,
  input  logic [10:0] pixelX_i,
  input  logic [10:0] pixelY_i,
  output logic [1:0]  state_o,
  output logic        hit_o,
  output logic [10:0] offX_o,
  output logic [10:0] offY_o
);
  localparam logic signed [12:0] W13  = 13'(OBJ_W);
  localparam logic signed [12:0] H13  = 13'(OBJ_H);
  localparam logic signed [12:0] YMIN = 13'(-OBJ_H);
  localparam logic signed [12:0] YMAX = 13'(SCREEN_H);

  slot_state_t state_q, state_d;
  owner_t      owner_q, owner_d;
  logic [10:0] x_q, x_d;  // X never moves, so only its integer part is kept
  pos_t        y_q, y_d;
  logic [15:0] speed_q, speed_d;

  logic signed [POS_W:0] y_next;  // one guard bit so the off-screen test cannot wrap
  logic signed [12:0]    y_next_int, y_int, xs, px, py;
  logic                  retire;

  always_comb begin
    if (owner_q == ENEMY)
      y_next = {y_q[POS_W-1], y_q} + $signed({{(POS_W-15){1'b0}}, speed_q});
    else
      y_next = {y_q[POS_W-1], y_q} - $signed({{(POS_W-15){1'b0}}, speed_q});
    y_next_int = y_next[POS_W:FRAC_BITS];
    retire     = (owner_q == ENEMY) ? (y_next_int >= YMAX) : (y_next_int < YMIN);
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    x_d     = x_q;
    y_d     = y_q;
    speed_d = speed_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (alloc_i) begin
          state_d = FLYING;
          owner_d = owner_t'(enemy_i);
          x_d     = x_i;
          y_d     = {1'b0, y_i, {FRAC_BITS{1'b0}}};
          speed_d = speed_i;
        end
        // a collision this cycle wins over the frame move
        FLYING: if (collide_i) begin
          state_d = HIT;
        end else if (frame_i) begin
          y_d = y_next[POS_W-1:0];
          if (retire) state_d = IDLE;
        end
        HIT: if (frame_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    y_int  = {y_q[POS_W-1], y_q[POS_W-1:FRAC_BITS]};
    xs     = {2'b00, x_q};
    px     = {2'b00, pixelX_i};
    py     = {2'b00, pixelY_i};
    hit_o  = (state_q == FLYING) && (px >= xs) && (px < xs + W13) &&
             (py >= y_int) && (py < y_int + H13);
    offX_o = pixelX_i - x_q;
    offY_o = 11'(py - y_int);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= PLAYER;
      x_q     <= '0;
      y_q     <= '0;
      speed_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      x_q     <= x_d;
      y_q     <= y_d;
      speed_q <= speed_d;
    end
  end

  assign state_o = state_q;
endmodule

// File: rtl/projectile_pool.sv
// Pool of projectile slots shared by player and enemy: fire edge detection,
// slot allocation, collision routing, prioritised draw mux and live count.
module projectile_pool
  import projectile_pkg::*;
#(
  parameter int NUM_SLOTS            = 4,
  parameter int OBJ_W                = 32,
  parameter int OBJ_H                = 32,
  parameter int SCREEN_H             = 480,
  parameter int PLAYER_SPEED         = 300,
  parameter int PLAYER_POWERUP_SPEED = 500,
  parameter int ENEMY_BASE_SPEED     = 130,
  parameter int LEVEL_SPEED_MOD      = 10
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        shootRequestPlayer,
  input  logic [10:0] playerX,
  input  logic [10:0] playerY,
  input  logic        shootRequestEnemy,
  input  logic [10:0] enemyX,
  input  logic [10:0] enemyY,
  input  logic        speedPowerup,
  input  logic [3:0]  level,
  input  logic        collision,
  input  logic        endLevel,
  output logic        beingShot,
  output logic        shotDropped,
  output logic [3:0]  activeCount,
  output logic        drawingRequest,
  output logic [2:0]  drawSlot,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY
);
  logic rst;
  assign rst = resetN;  // despite the name, 1 = reset

  logic [NUM_SLOTS-1:0]       idle, alloc_p, alloc_e, collide, hit;
  logic [NUM_SLOTS-1:0][1:0]  st;
  logic [NUM_SLOTS-1:0][10:0] off_x, off_y;
  logic [15:0] player_speed, enemy_speed;
  logic        p_rise, e_rise, p_ok, e_ok;
  logic        prevP_q, prevE_q, beingShot_q, shotDropped_q;
  logic        draw_q, draw_d;
  logic [2:0]  slot_q, slot_d;
  logic [10:0] offX_q, offX_d, offY_q, offY_d;
  logic [3:0]  count;

  assign p_rise       = shootRequestPlayer & ~prevP_q;
  assign e_rise       = shootRequestEnemy & ~prevE_q;
  assign player_speed = speedPowerup ? 16'(PLAYER_POWERUP_SPEED) : 16'(PLAYER_SPEED);
  assign enemy_speed  = 16'(ENEMY_BASE_SPEED) + 16'(level) * 16'(LEVEL_SPEED_MOD);

  // Player gets the lowest idle slot, enemy the lowest one the player left.
  always_comb begin
    alloc_p = '0;
    alloc_e = '0;
    p_ok    = 1'b0;
    e_ok    = 1'b0;
    if (!endLevel) begin
      for (int i = 0; i < NUM_SLOTS; i++)
        if (p_rise && !p_ok && idle[i]) begin
          alloc_p[i] = 1'b1;
          p_ok       = 1'b1;
        end
      for (int i = 0; i < NUM_SLOTS; i++)
        if (e_rise && !e_ok && idle[i] && !alloc_p[i]) begin
          alloc_e[i] = 1'b1;
          e_ok       = 1'b1;
        end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    assign idle[g]    = (st[g] == IDLE);
    assign collide[g] = collision && draw_q && (slot_q == 3'(g));

    projectile_slot #(
      .OBJ_W(OBJ_W), .OBJ_H(OBJ_H), .SCREEN_H(SCREEN_H)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .alloc_i  (alloc_p[g] | alloc_e[g]),
      .enemy_i  (alloc_e[g]),
      .x_i      (alloc_e[g] ? enemyX : playerX),
      .y_i      (alloc_e[g] ? enemyY : playerY),
      .speed_i  (alloc_e[g] ? enemy_speed : player_speed),
      .frame_i  (startOfFrame),
      .collide_i(collide[g]),
      .flush_i  (endLevel),
      .pixelX_i (pixelX),
      .pixelY_i (pixelY),
      .state_o  (st[g]),
      .hit_o    (hit[g]),
      .offX_o   (off_x[g]),
      .offY_o   (off_y[g])
    );
  end

  // Scan downwards so the lowest-index hitting slot is the last one written.
  always_comb begin
    draw_d = 1'b0;
    slot_d = '0;
    offX_d = '0;
    offY_d = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (hit[i]) begin
        draw_d = 1'b1;
        slot_d = 3'(i);
        offX_d = off_x[i];
        offY_d = off_y[i];
      end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_SLOTS; i++) count = count + {3'b000, ~idle[i]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prevP_q       <= 1'b0;
      prevE_q       <= 1'b0;
      beingShot_q   <= 1'b0;
      shotDropped_q <= 1'b0;
      draw_q        <= 1'b0;
      slot_q        <= '0;
      offX_q        <= '0;
      offY_q        <= '0;
    end else begin
      prevP_q       <= shootRequestPlayer;
      prevE_q       <= shootRequestEnemy;
      beingShot_q   <= p_ok | e_ok;
      shotDropped_q <= (p_rise & ~p_ok) | (e_rise & ~e_ok);
      draw_q        <= draw_d;
      slot_q        <= slot_d;
      offX_q        <= offX_d;
      offY_q        <= offY_d;
    end
  end

  assign beingShot      = beingShot_q;
  assign shotDropped    = shotDropped_q;
  assign activeCount    = count;
  assign drawingRequest = draw_q;
  assign drawSlot       = slot_q;
  assign offsetX        = offX_q;
  assign offsetY        = offY_q;
endmodule

// File: tb/tb_projectile_pool.sv
// Bench for projectile_pool: vector table, directed multi-cycle sequences and
// randomized traffic, all checked against a behavioural model of the pool.
module tb_projectile_pool;
  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic [10:0] pixelX = 11'd1000, pixelY = 11'd1000;
  logic        shootRequestPlayer = 1'b0, shootRequestEnemy = 1'b0;
  logic [10:0] playerX = 11'd100, playerY = 11'd400, enemyX = 11'd200, enemyY = 11'd0;
  logic        speedPowerup = 1'b0, collision = 1'b0, endLevel = 1'b0;
  logic [3:0]  level = 4'd3;
  logic        beingShot, shotDropped, drawingRequest;
  logic [3:0]  activeCount;
  logic [2:0]  drawSlot;
  logic [10:0] offsetX, offsetY;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  projectile_pool #(.NUM_SLOTS(NS)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY),
    .shootRequestPlayer(shootRequestPlayer), .playerX(playerX), .playerY(playerY),
    .shootRequestEnemy(shootRequestEnemy), .enemyX(enemyX), .enemyY(enemyY),
    .speedPowerup(speedPowerup), .level(level), .collision(collision), .endLevel(endLevel),
    .beingShot(beingShot), .shotDropped(shotDropped), .activeCount(activeCount),
    .drawingRequest(drawingRequest), .drawSlot(drawSlot),
    .offsetX(offsetX), .offsetY(offsetY)
  );

  // ---------------- reference model (0 idle, 1 flying, 2 hit; y in 1/64 px)
  int m_st[NS], m_x[NS], m_y[NS], m_spd[NS];
  bit m_en[NS];
  bit m_pp, m_pe, m_bs, m_sd, m_dr;
  int m_ds, m_ox, m_oy;

  function automatic int fl64(int v);
    return (v >= 0) ? v / 64 : -((-v + 63) / 64);
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < NS; i++) if (m_st[i] != 0) c++;
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NS; i++) begin
      m_st[i] = 0; m_x[i] = 0; m_y[i] = 0; m_spd[i] = 0; m_en[i] = 0;
    end
    m_pp = 0; m_pe = 0; m_bs = 0; m_sd = 0; m_dr = 0; m_ds = 0; m_ox = 0; m_oy = 0;
  endtask

  task automatic m_launch(int s, bit en);
    m_st[s] = 1;
    m_en[s] = en;
    m_x[s]  = en ? int'(enemyX) : int'(playerX);
    m_y[s]  = 64 * (en ? int'(enemyY) : int'(playerY));
    m_spd[s] = en ? 130 + 10 * int'(level) : (speedPowerup ? 500 : 300);
    m_bs = 1;
  endtask

  task automatic model_clock();
    int q[$];
    int px, py, iy, hds, hox, hoy;
    bit pr, er, hdr, col;
    px = int'(pixelX); py = int'(pixelY);
    hdr = 0; hds = 0; hox = 0; hoy = 0;
    for (int i = 0; i < NS; i++) begin
      iy = fl64(m_y[i]);
      if (!hdr && m_st[i] == 1 && px >= m_x[i] && px < m_x[i] + 32 && py >= iy && py < iy + 32) begin
        hdr = 1; hds = i; hox = (px - m_x[i]) & 2047; hoy = (py - iy) & 2047;
      end
    end
    pr = shootRequestPlayer && !m_pp;
    er = shootRequestEnemy && !m_pe;
    m_pp = shootRequestPlayer; m_pe = shootRequestEnemy;
    col = collision && m_dr;
    for (int i = 0; i < NS; i++) if (m_st[i] == 0) q.push_back(i);
    m_bs = 0; m_sd = 0;
    if (endLevel) begin
      for (int i = 0; i < NS; i++) m_st[i] = 0;
      m_sd = pr || er;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (col && i == m_ds && m_st[i] == 1) m_st[i] = 2;
        else if (startOfFrame) begin
          if (m_st[i] == 2) m_st[i] = 0;
          else if (m_st[i] == 1) begin
            m_y[i] += m_en[i] ? m_spd[i] : -m_spd[i];
            iy = fl64(m_y[i]);
            if ((m_en[i] && iy >= 480) || (!m_en[i] && iy < -32)) m_st[i] = 0;
          end
        end
      end
      if (pr) begin
        if (q.size() > 0) m_launch(q.pop_front(), 0); else m_sd = 1;
      end
      if (er) begin
        if (q.size() > 0) m_launch(q.pop_front(), 1); else m_sd = 1;
      end
    end
    m_dr = hdr; m_ds = hds; m_ox = hox; m_oy = hoy;
  endtask

  // ---------------- checking helpers
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_clock();
    chk("model.beingShot", 32'(beingShot), 32'(m_bs));
    chk("model.shotDropped", 32'(shotDropped), 32'(m_sd));
    chk("model.activeCount", 32'(activeCount), 32'(m_count()));
    chk("model.drawingRequest", 32'(drawingRequest), 32'(m_dr));
    chk("model.drawSlot", 32'(drawSlot), 32'(m_ds));
    chk("model.offsetX", 32'(offsetX), 32'(m_ox));
    chk("model.offsetY", 32'(offsetY), 32'(m_oy));
  endtask

  task automatic frame();
    startOfFrame = 1'b1; tick();
    startOfFrame = 1'b0; tick();
  endtask

  // Reset is raised between clock edges; outputs must clear without a clock.
  task automatic do_reset();
    #2;
    shootRequestPlayer = 0; shootRequestEnemy = 0; startOfFrame = 0;
    collision = 0; endLevel = 0;
    resetN = 1'b1;
    #1;
    chk("rst.beingShot", 32'(beingShot), 0);
    chk("rst.shotDropped", 32'(shotDropped), 0);
    chk("rst.activeCount", 32'(activeCount), 0);
    chk("rst.drawingRequest", 32'(drawingRequest), 0);
    chk("rst.drawSlot", 32'(drawSlot), 0);
    chk("rst.offsetX", 32'(offsetX), 0);
    chk("rst.offsetY", 32'(offsetY), 0);
    m_reset();
    @(posedge clk); @(posedge clk); #1;
    resetN = 1'b0;
  endtask

  typedef struct {
    logic sp, se, el;
    int   px, py;
    logic bs, sd;
    int   cnt;
    logic dr;
    int   ds, ox, oy;
  } vec_t;

  vec_t tbl[12];

  initial begin
    // sp se el  px    py   | bs sd cnt dr ds ox oy
    tbl[0]  = '{0, 0, 0, 1000, 1000, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 1000, 1000, 1, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 110,  410,  0, 0, 1, 1, 0, 10, 10};
    tbl[3]  = '{0, 1, 0, 1000, 1000, 1, 0, 2, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 0, 1000, 1000, 1, 0, 3, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 1000, 1000, 0, 0, 3, 0, 0, 0, 0};
    tbl[6]  = '{1, 1, 0, 1000, 1000, 1, 1, 4, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 1000, 1000, 0, 0, 4, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 0, 1000, 1000, 0, 1, 4, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 1000, 1000, 0, 0, 4, 0, 0, 0, 0};
    tbl[10] = '{1, 0, 1, 1000, 1000, 0, 1, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 1000, 1000, 0, 0, 0, 0, 0, 0, 0};

    do_reset();

    // allocation, fill, drop, endLevel flush
    for (int r = 0; r < 12; r++) begin
      shootRequestPlayer = tbl[r].sp;
      shootRequestEnemy  = tbl[r].se;
      endLevel           = tbl[r].el;
      pixelX = 11'(tbl[r].px);
      pixelY = 11'(tbl[r].py);
      tick();
      chk("tbl.beingShot", 32'(beingShot), 32'(tbl[r].bs));
      chk("tbl.shotDropped", 32'(shotDropped), 32'(tbl[r].sd));
      chk("tbl.activeCount", 32'(activeCount), 32'(tbl[r].cnt));
      chk("tbl.drawingRequest", 32'(drawingRequest), 32'(tbl[r].dr));
      chk("tbl.drawSlot", 32'(drawSlot), 32'(tbl[r].ds));
      chk("tbl.offsetX", 32'(offsetX), 32'(tbl[r].ox));
      chk("tbl.offsetY", 32'(offsetY), 32'(tbl[r].oy));
    end

    // player shot: 64 frames at 300/64 px moves from Y=400 to Y=100
    do_reset();
    playerX = 100; playerY = 400; speedPowerup = 0;
    pixelX = 1000; pixelY = 1000;
    shootRequestPlayer = 1; tick();
    chk("A.beingShot", 32'(beingShot), 1);
    shootRequestPlayer = 0;
    for (int f = 0; f < 64; f++) frame();
    pixelX = 110; pixelY = 110; tick();
    chk("A.drawingRequest", 32'(drawingRequest), 1);
    chk("A.drawSlot", 32'(drawSlot), 0);
    chk("A.offsetX", 32'(offsetX), 10);
    chk("A.offsetY", 32'(offsetY), 10);
    pixelY = 99; tick();
    chk("A.aboveTop", 32'(drawingRequest), 0);

    // simultaneous launch; powered player leaves the top, enemy the bottom
    do_reset();
    pixelX = 1000; pixelY = 1000;
    playerX = 300; playerY = 0; speedPowerup = 1;
    enemyX = 200; enemyY = 0; level = 3;
    shootRequestPlayer = 1; shootRequestEnemy = 1; tick();
    chk("B.beingShot", 32'(beingShot), 1);
    chk("B.shotDropped", 32'(shotDropped), 0);
    chk("B.count2", 32'(activeCount), 2);
    shootRequestPlayer = 0; shootRequestEnemy = 0; speedPowerup = 0;
    for (int f = 0; f < 4; f++) frame();
    chk("B.playerAtMinus32", 32'(activeCount), 2);
    frame();
    chk("B.playerRetired", 32'(activeCount), 1);
    for (int f = 5; f < 10; f++) frame();
    pixelX = 200; pixelY = 25; tick();
    chk("B.enemyY25.dr", 32'(drawingRequest), 1);
    chk("B.enemyY25.slot", 32'(drawSlot), 1);
    chk("B.enemyY25.offY", 32'(offsetY), 0);
    pixelY = 24; tick();
    chk("B.enemyY24.dr", 32'(drawingRequest), 0);
    pixelX = 1000; pixelY = 1000;
    for (int f = 10; f < 191; f++) frame();
    chk("B.enemyY477", 32'(activeCount), 1);
    frame();
    chk("B.enemyRetired", 32'(activeCount), 0);

    // overlap priority and collision retirement
    do_reset();
    playerX = 100; playerY = 400; enemyX = 500; enemyY = 100;
    pixelX = 1000; pixelY = 1000;
    shootRequestPlayer = 1; tick();
    shootRequestPlayer = 0; shootRequestEnemy = 1; tick();
    shootRequestEnemy = 0; shootRequestPlayer = 1; tick();
    shootRequestPlayer = 0; tick();
    pixelX = 110; pixelY = 410; tick();
    chk("C.overlap.dr", 32'(drawingRequest), 1);
    chk("C.overlap.slot", 32'(drawSlot), 0);
    collision = 1; tick();
    collision = 0;
    chk("C.collideCycle.slot", 32'(drawSlot), 0);
    tick();
    chk("C.afterHit.dr", 32'(drawingRequest), 1);
    chk("C.afterHit.slot", 32'(drawSlot), 2);
    chk("C.afterHit.count", 32'(activeCount), 3);
    startOfFrame = 1; tick();
    startOfFrame = 0;
    chk("C.hitReleased", 32'(activeCount), 2);
    tick();
    chk("C.slot2.slot", 32'(drawSlot), 2);

    // asynchronous reset mid-flight
    do_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("E.noBeingShot", 32'(beingShot), 0);
    end

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int k;
      shootRequestPlayer = ($urandom_range(0, 2) == 0);
      shootRequestEnemy  = ($urandom_range(0, 2) == 0);
      playerX = 11'($urandom_range(0, 639));
      playerY = 11'($urandom_range(32, 479));
      enemyX  = 11'($urandom_range(0, 639));
      enemyY  = 11'($urandom_range(0, 300));
      level   = 4'($urandom_range(0, 15));
      speedPowerup = 1'($urandom_range(0, 1));
      startOfFrame = ($urandom_range(0, 3) == 0);
      collision    = ($urandom_range(0, 2) == 0);
      endLevel     = ($urandom_range(0, 199) == 0);
      k = int'($urandom_range(0, NS - 1));
      if (m_st[k] != 0 && $urandom_range(0, 3) != 0) begin
        pixelX = 11'(m_x[k] + int'($urandom_range(0, 35)) - 2);
        pixelY = 11'(fl64(m_y[k]) + int'($urandom_range(0, 35)) - 2);
      end else begin
        pixelX = 11'($urandom_range(0, 700));
        pixelY = 11'($urandom_range(0, 700));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
